// File: rtl/dmem_pkg.sv
// Shared types and the address-check helper for the data-memory responder.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } req_t;

  // Word-aligned and below depth words; widened so a 2^30-word array cannot overflow the limit.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned depth);
    logic [ADDR_W+1:0] limit;
    limit = (ADDR_W+2)'(depth) << 2;
    return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between a requester and the responder.
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 storage with synchronous write and clear; read data is the addressed word
// before any write on the current edge, so a caller sampling it there gets read-before-write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 16384
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] index,
  input  logic [WORD_W-1:0]        wdata,
  output logic [WORD_W-1:0]        rdata_c
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= '0;
      end
    end else if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata_c = mem[index];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle load/store responder: one outstanding request, fixed LATENCY from accept
// to response, registered response held until the requester consumes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 16384,
  parameter int unsigned LATENCY = 4
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  req_t              cap, cap_nx;
  logic              ready, ready_nx;
  logic              valid, valid_nx;
  logic              err, err_nx;
  logic [WORD_W-1:0] rdata, rdata_nx;

  logic              arr_we;
  logic              access_ok;
  logic [IDX_W-1:0]  arr_index;
  logic [WORD_W-1:0] arr_rdata_c;

  assign arr_index = cap.addr[IDX_W+1:2];
  assign access_ok = addr_ok(cap.addr, DEPTH);

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .reset   (reset),
    .we      (arr_we),
    .index   (arr_index),
    .wdata   (cap.wdata),
    .rdata_c (arr_rdata_c)
  );

  // State, capture and response registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      cap   <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cap   <= cap_nx;
      ready <= ready_nx;
      valid <= valid_nx;
      err   <= err_nx;
      rdata <= rdata_nx;
    end
  end

  // Next state, latency countdown and the access performed on the last BUSY edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cap_nx   = cap;
    ready_nx = ready;
    valid_nx = valid;
    err_nx   = err;
    rdata_nx = rdata;
    arr_we   = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          cap_nx   = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata};
          cnt_nx   = CNT_W'(LATENCY - 1);
          ready_nx = 1'b0;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          arr_we   = cap.we & access_ok;
          rdata_nx = (!cap.we && access_ok) ? arr_rdata_c : '0;
          err_nx   = ~access_ok;
          valid_nx = 1'b1;
          state_nx = RESP;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          valid_nx = 1'b0;
          ready_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        valid_nx = 1'b0;
      end
    endcase
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = valid;
  assign bus.resp_rdata = rdata;
  assign bus.resp_err   = err;

endmodule
